// File: rtl/fu_issue_fifo.sv
// fu_issue_fifo: per-functional-unit issue queue taking up to three lanes per cycle from the RS.
// Optional same-cycle bypass when empty is enabled by defining FU_FIFO_BYPASS_EN.
`default_nettype none

package fu_issue_pkg;
  typedef enum logic [2:0] {ALU_1, ALU_2, ALU_3, MULT_1, MULT_2, BRANCH, LS_1, LS_2} FU_SELECT;

  typedef struct packed {
    logic        valid;
    FU_SELECT    fu_sel;
    logic [31:0] pc;
    logic [5:0]  dest_tag;
  } RS_S_PACKET;
endpackage

module fu_issue_fifo
  import fu_issue_pkg::*;
#(
  parameter int       DEPTH  = 8,
  parameter FU_SELECT FU_SEL = ALU_1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  RS_S_PACKET [2:0]         issue_insts,
  input  logic                     squash,
  input  logic                     fu_ready,
  output logic                     fu_valid,
  output RS_S_PACKET               fu_packet,
  output logic                     fifo_stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  RS_S_PACKET    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [2:0]    match, take, push_mask;
  logic [1:0]    n_push;
  logic          pop, head_valid;
  logic [PW-1:0] slot [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      match[i] = issue_insts[i].valid && (issue_insts[i].fu_sel == FU_SEL);
    end
  end

  // Stall looks only at registered occupancy so it never depends on this cycle's pop.
  assign fifo_stall = count_q > CW'(DEPTH - 3);
  assign head_valid = count_q != '0;
  assign pop        = head_valid & fu_ready;

`ifdef FU_FIFO_BYPASS_EN
  logic byp_en;

  always_comb begin
    byp_en = reset && !head_valid && !squash && !fifo_stall && (|match);
    take   = '0;
    if (byp_en && fu_ready) begin
      if (match[2])      take[2] = 1'b1;
      else if (match[1]) take[1] = 1'b1;
      else               take[0] = 1'b1;
    end
    fu_valid  = head_valid | byp_en;
    fu_packet = '0;
    if (head_valid)    fu_packet = mem_q[head_q];
    else if (byp_en)   fu_packet = match[2] ? issue_insts[2] :
                                   match[1] ? issue_insts[1] : issue_insts[0];
  end
`else
  always_comb begin
    take      = '0;
    fu_valid  = head_valid;
    fu_packet = head_valid ? mem_q[head_q] : '0;
  end
`endif

  always_comb begin
    push_mask = match & ~take & {3{~(fifo_stall | squash)}};
    n_push    = 2'(push_mask[0]) + 2'(push_mask[1]) + 2'(push_mask[2]);
    // Lane 2 lands at the tail, lower lanes pack in behind it.
    slot[2]   = tail_q;
    slot[1]   = tail_q + PW'(push_mask[2]);
    slot[0]   = tail_q + PW'(push_mask[2]) + PW'(push_mask[1]);

    ovf_d = ovf_q | (fifo_stall & (|match));
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(n_push);
      count_d = count_q + CW'(n_push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (push_mask[i]) mem_q[slot[i]] <= issue_insts[i];
    end
  end

  assign count        = count_q;
  assign overflow_err = ovf_q;

endmodule

`default_nettype wire

// File: doc/fu_issue_fifo.md
FU_ISSUE_FIFO -- requirements
Module: fu_issue_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries; must be a power of two and at least 4.
REQ-002 SHALL have parameter FU_SEL, default ALU_1, the functional-unit class this instance accepts.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port issue_insts, input, RS_S_PACKET[2:0], the three issue lanes from the reservation station.
REQ-006 SHALL have port squash, input, 1, flushes all entries (branch recovery).
REQ-007 SHALL have port fu_ready, input, 1, the FU accepts the head packet this cycle.
REQ-008 SHALL have port fu_valid, output, 1, the head packet is valid.
REQ-009 SHALL have port fu_packet, output, RS_S_PACKET, the head packet; all-zero when fu_valid=0.
REQ-010 SHALL have port fifo_stall, output, 1, feeds the matching field of fu_fifo_stall.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-012 SHALL have port overflow_err, output, 1, sticky error flag.

Function
REQ-013 SHALL treat lane i as matching when issue_insts[i].valid=1 and issue_insts[i].fu_sel==FU_SEL; non-matching lanes are ignored.
REQ-014 SHALL enqueue matching lanes in the order lane 2, then lane 1, then lane 0, into consecutive slots at the tail.
REQ-015 SHALL accept 0 to 3 pushes per cycle and at most 1 pop per cycle.
REQ-016 SHALL pop when fu_valid=1 and fu_ready=1; the head then advances by one.
REQ-017 SHALL ignore fu_ready when the FIFO is empty.
REQ-018 SHALL update count as count + pushes - pop on each edge.
REQ-019 SHALL wrap head and tail pointers modulo DEPTH.
REQ-020 SHALL assert fifo_stall combinationally from registered count when (DEPTH - count) < 3, independent of same-cycle pops.
REQ-021 SHALL drop all matching lanes arriving while fifo_stall=1 and set overflow_err, which stays set until reset.
REQ-022 SHALL, when squash=1, set count, head and tail to 0 at the next edge and drop all same-cycle pushes; squash takes priority over pushes.
REQ-023 SHALL still complete a handshaken pop in the squash cycle (the FU consumes it) before the FIFO empties.
REQ-024 SHALL make a pushed packet visible on fu_packet no earlier than the cycle after the push (1-cycle minimum latency), except as in REQ-030.
REQ-025 SHALL allow push and pop in the same cycle at any occupancy, including full minus 3.

Reset
REQ-026 SHALL, while reset=0, clear head, tail, count and overflow_err to 0 and drive fu_valid=0, fu_packet=0 and fifo_stall=0, asynchronously.
REQ-027 SHALL leave entry storage contents unspecified after reset; storage is never observable while count=0.
REQ-028 SHALL abandon any in-flight operation when reset asserts mid-cycle; no partial push survives.

Configuration
REQ-029 SHALL use macro FU_FIFO_BYPASS_EN.
REQ-030 SHALL, with FU_FIFO_BYPASS_EN defined, pass the first matching lane (per REQ-014 order) directly to fu_packet/fu_valid in the same cycle when count=0, squash=0 and fifo_stall=0.
- If fu_ready=1 in that case, the bypassed lane is not enqueued; the remaining lanes enqueue.
REQ-031 SHALL, without FU_FIFO_BYPASS_EN, drive fu_packet only from stored entries (strict 1-cycle latency).

Verification
REQ-032 SHALL test ordering: DEPTH=8, empty; lanes 2, 1 and 0 all match with PCs 0x10, 0x14, 0x18 and fu_ready=1 -> pops over the next 3 cycles in PC order 0x10, 0x14, 0x18; count goes 3, 2, 1, 0.
REQ-033 SHALL test the stall threshold: fill to count=5, then push 1 with no pop -> count=6 and fifo_stall=1; pop 1 -> count=5 and fifo_stall=0.
REQ-034 SHALL test overflow: force 2 matching lanes while count=6 -> count unchanged and overflow_err=1 until reset.
REQ-035 SHALL test squash: count=4, push 2 and pop 1 with squash=1 -> count=0 and fu_valid=0 the next cycle; the popped packet was delivered.
REQ-036 SHALL test wrap-around: 20 push/pop cycles with 1 push and 1 pop each -> data order preserved across the pointer wrap; count constant.
REQ-037 SHALL test bypass: with FU_FIFO_BYPASS_EN defined, empty, one matching lane with PC 0x40 and fu_ready=1 -> fu_valid=1 with PC 0x40 in the same cycle and count stays 0; with the macro undefined -> fu_valid rises one cycle later.
